// File: rtl/body_rate_controller.sv
// Inner-loop PI rate stage: one saturated P+I update per start pulse for yaw/pitch/roll, plus a throttle clamp.
// Latency 4 edges from start to complete; start ignored while busy (min period 6), outputs hold between updates.
module body_rate_controller #(
    parameter int                          RATE_BIT_WIDTH = 16,
    parameter logic [RATE_BIT_WIDTH-1:0]   KP             = 16'h0020,
    parameter int                          KI_SHIFT       = 6,
    parameter logic [23:0]                 INT_LIMIT      = 24'h004000,
    parameter logic [RATE_BIT_WIDTH-1:0]   RATE_LIMIT     = 16'h0C80,
    parameter logic [RATE_BIT_WIDTH-1:0]   THROTTLE_IDLE  = 16'h0050,
    parameter logic [RATE_BIT_WIDTH-1:0]   THROTTLE_MAX   = 16'h0FA0
) (
    input  logic                      us_clk,
    input  logic                      resetn,
    input  logic                      start_signal,
    input  logic [RATE_BIT_WIDTH-1:0] throttle_rate_target,
    input  logic [RATE_BIT_WIDTH-1:0] yaw_rate_target,
    input  logic [RATE_BIT_WIDTH-1:0] pitch_rate_target,
    input  logic [RATE_BIT_WIDTH-1:0] roll_rate_target,
    input  logic [RATE_BIT_WIDTH-1:0] yaw_rate_actual,
    input  logic [RATE_BIT_WIDTH-1:0] pitch_rate_actual,
    input  logic [RATE_BIT_WIDTH-1:0] roll_rate_actual,
    output logic [RATE_BIT_WIDTH-1:0] throttle_out,
    output logic [RATE_BIT_WIDTH-1:0] yaw_rate_out,
    output logic [RATE_BIT_WIDTH-1:0] pitch_rate_out,
    output logic [RATE_BIT_WIDTH-1:0] roll_rate_out,
    output logic                      active_signal,
    output logic                      complete_signal
);

    localparam int W    = RATE_BIT_WIDTH;
    localparam int PW   = 2 * W;
    localparam int IW   = 24;
    localparam int FRAC = 4;

    localparam logic signed [PW-1:0] MAX_W     = PW'((2 ** (W - 1)) - 1);
    localparam logic signed [PW-1:0] MIN_W     = -MAX_W - PW'(1);
    localparam logic signed [PW-1:0] KP_S      = PW'(KP);
    localparam logic signed [PW-1:0] RL_P      = PW'(RATE_LIMIT);
    localparam logic signed [PW-1:0] RL_N      = -RL_P;
    localparam logic signed [PW-1:0] THR_MAX_S = PW'(THROTTLE_MAX);
    localparam logic signed [IW:0]   ILIM_P    = (IW + 1)'(INT_LIMIT);
    localparam logic signed [IW:0]   ILIM_N    = -ILIM_P;

    typedef enum logic [5:0] {
        S_WAITING     = 6'b000001,
        S_ERROR       = 6'b000010,
        S_SCALING     = 6'b000100,
        S_INTEGRATING = 6'b001000,
        S_LIMITING    = 6'b010000,
        S_COMPLETE    = 6'b100000
    } state_t;

    state_t state;

    // Axis index: 0 = yaw, 1 = pitch, 2 = roll.
    logic signed [W-1:0]  tgt_q   [3];
    logic signed [W-1:0]  act_q   [3];
    logic signed [W-1:0]  err_q   [3];
    logic signed [W-1:0]  p_q     [3];
    logic signed [IW-1:0] integ_q [3];
    logic signed [W-1:0]  rate_q  [3];
    logic signed [W-1:0]  thr_q;
    logic        [W-1:0]  thr_out_q;

    logic signed [W-1:0]  err_d   [3];
    logic signed [W-1:0]  p_d     [3];
    logic signed [IW:0]   isum    [3];
    logic signed [IW-1:0] integ_d [3];
    logic signed [W-1:0]  i_d     [3];
    logic signed [W-1:0]  rate_d  [3];
    logic        [W-1:0]  thr_out_d;
    logic                 thr_clear;

    function automatic logic [W-1:0] clamp_w(input logic signed [PW-1:0] v,
                                             input logic signed [PW-1:0] lo,
                                             input logic signed [PW-1:0] hi);
        if (v < lo)
            return lo[W-1:0];
        else if (v > hi)
            return hi[W-1:0];
        else
            return v[W-1:0];
    endfunction

    function automatic logic [W-1:0] sat_w(input logic signed [PW-1:0] v);
        return clamp_w(v, MIN_W, MAX_W);
    endfunction

    assign thr_clear = thr_q < $signed(THROTTLE_IDLE);
    assign thr_out_d = clamp_w(PW'(thr_q), '0, THR_MAX_S);

    always_comb begin
        for (int a = 0; a < 3; a++) begin
            err_d[a] = sat_w(PW'(tgt_q[a]) - PW'(act_q[a]));
            p_d[a]   = sat_w((PW'(err_q[a]) * KP_S) >>> FRAC);
            isum[a]  = (IW + 1)'(integ_q[a]) + (IW + 1)'(err_q[a]);
            if (thr_clear)
                integ_d[a] = '0;
            else if (isum[a] > ILIM_P)
                integ_d[a] = ILIM_P[IW-1:0];
            else if (isum[a] < ILIM_N)
                integ_d[a] = ILIM_N[IW-1:0];
            else
                integ_d[a] = isum[a][IW-1:0];
            // integ_q already holds this pass's updated value when LIMITING reads it.
            i_d[a]    = sat_w(PW'(integ_q[a] >>> KI_SHIFT));
            rate_d[a] = clamp_w(PW'(p_q[a]) + PW'(i_d[a]), RL_N, RL_P);
        end
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state           <= S_WAITING;
            active_signal   <= 1'b0;
            complete_signal <= 1'b0;
            thr_q           <= '0;
            thr_out_q       <= '0;
            for (int a = 0; a < 3; a++) begin
                tgt_q[a]   <= '0;
                act_q[a]   <= '0;
                err_q[a]   <= '0;
                p_q[a]     <= '0;
                integ_q[a] <= '0;
                rate_q[a]  <= '0;
            end
        end else begin
            case (state)
                S_WAITING: begin
                    if (start_signal) begin
                        thr_q         <= throttle_rate_target;
                        tgt_q[0]      <= yaw_rate_target;
                        tgt_q[1]      <= pitch_rate_target;
                        tgt_q[2]      <= roll_rate_target;
                        act_q[0]      <= yaw_rate_actual;
                        act_q[1]      <= pitch_rate_actual;
                        act_q[2]      <= roll_rate_actual;
                        active_signal <= 1'b1;
                        state         <= S_ERROR;
                    end
                end
                S_ERROR: begin
                    for (int a = 0; a < 3; a++) err_q[a] <= err_d[a];
                    state <= S_SCALING;
                end
                S_SCALING: begin
                    for (int a = 0; a < 3; a++) p_q[a] <= p_d[a];
                    state <= S_INTEGRATING;
                end
                S_INTEGRATING: begin
                    for (int a = 0; a < 3; a++) integ_q[a] <= integ_d[a];
                    state <= S_LIMITING;
                end
                S_LIMITING: begin
                    for (int a = 0; a < 3; a++) rate_q[a] <= rate_d[a];
                    thr_out_q       <= thr_out_d;
                    complete_signal <= 1'b1;
                    active_signal   <= 1'b0;
                    state           <= S_COMPLETE;
                end
                S_COMPLETE: begin
                    complete_signal <= 1'b0;
                    state           <= S_WAITING;
                end
                default: begin
                    // Corrupted encoding: drop the update, keep the last published commands.
                    active_signal   <= 1'b0;
                    complete_signal <= 1'b0;
                    state           <= S_WAITING;
                end
            endcase
        end
    end

    assign throttle_out   = thr_out_q;
    assign yaw_rate_out   = rate_q[0];
    assign pitch_rate_out = rate_q[1];
    assign roll_rate_out  = rate_q[2];

endmodule

// File: tb/tb_body_rate_controller.sv
// Directed and randomized bench for body_rate_controller against an integer reference model.
module tb_body_rate_controller;

    logic        us_clk = 1'b0;
    logic        resetn;
    logic        start_signal;
    logic [15:0] throttle_rate_target;
    logic [15:0] yaw_rate_target, pitch_rate_target, roll_rate_target;
    logic [15:0] yaw_rate_actual, pitch_rate_actual, roll_rate_actual;
    logic [15:0] throttle_out, yaw_rate_out, pitch_rate_out, roll_rate_out;
    logic        active_signal, complete_signal;

    int n_tests = 0;
    int n_fail  = 0;
    int m_integ  [3];
    int exp_rate [3];
    int exp_thr;

    always #5 us_clk = ~us_clk;

    body_rate_controller dut (
        .us_clk               (us_clk),
        .resetn               (resetn),
        .start_signal         (start_signal),
        .throttle_rate_target (throttle_rate_target),
        .yaw_rate_target      (yaw_rate_target),
        .pitch_rate_target    (pitch_rate_target),
        .roll_rate_target     (roll_rate_target),
        .yaw_rate_actual      (yaw_rate_actual),
        .pitch_rate_actual    (pitch_rate_actual),
        .roll_rate_actual     (roll_rate_actual),
        .throttle_out         (throttle_out),
        .yaw_rate_out         (yaw_rate_out),
        .pitch_rate_out       (pitch_rate_out),
        .roll_rate_out        (roll_rate_out),
        .active_signal        (active_signal),
        .complete_signal      (complete_signal)
    );

    task automatic tick;
        @(posedge us_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    // Reference: rates in 1/16 deg/s units, KP = 2.0, integrator gain 1/64.
    task automatic model_step(input logic [15:0] thr,
                              input logic [15:0] ty, input logic [15:0] tp, input logic [15:0] tr,
                              input logic [15:0] ay, input logic [15:0] ap, input logic [15:0] ar);
        int t [3];
        int a [3];
        int err, p, i;
        t[0] = int'($signed(ty)); t[1] = int'($signed(tp)); t[2] = int'($signed(tr));
        a[0] = int'($signed(ay)); a[1] = int'($signed(ap)); a[2] = int'($signed(ar));
        for (int k = 0; k < 3; k++) begin
            err = sat(t[k] - a[k], -32768, 32767);
            p   = sat(err * 2, -32768, 32767);
            if (int'($signed(thr)) < 80)
                m_integ[k] = 0;
            else
                m_integ[k] = sat(m_integ[k] + err, -16384, 16384);
            i = sat(m_integ[k] >>> 6, -32768, 32767);
            exp_rate[k] = sat(p + i, -3200, 3200);
        end
        exp_thr = sat(int'($signed(thr)), 0, 4000);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":yaw"},   yaw_rate_out,   16'(exp_rate[0]));
        check({tag, ":pitch"}, pitch_rate_out, 16'(exp_rate[1]));
        check({tag, ":roll"},  roll_rate_out,  16'(exp_rate[2]));
        check({tag, ":thr"},   throttle_out,   16'(exp_thr));
    endtask

    task automatic run_update(input string tag, input logic [15:0] thr,
                              input logic [15:0] ty, input logic [15:0] tp, input logic [15:0] tr,
                              input logic [15:0] ay, input logic [15:0] ap, input logic [15:0] ar);
        int n;
        throttle_rate_target = thr;
        yaw_rate_target = ty; pitch_rate_target = tp; roll_rate_target = tr;
        yaw_rate_actual = ay; pitch_rate_actual = ap; roll_rate_actual = ar;
        start_signal = 1'b1;
        tick;
        start_signal = 1'b0;
        model_step(thr, ty, tp, tr, ay, ap, ar);
        check({tag, ":active_e0"}, 16'(active_signal), 16'h0001);
        // Inputs are only sampled at the start edge; scramble them mid-update.
        throttle_rate_target = 16'($urandom);
        yaw_rate_target = 16'($urandom); pitch_rate_target = 16'($urandom);
        roll_rate_target = 16'($urandom); yaw_rate_actual = 16'($urandom);
        pitch_rate_actual = 16'($urandom); roll_rate_actual = 16'($urandom);
        n = 0;
        while (n < 8) begin
            tick;
            n++;
            if (complete_signal === 1'b1) break;
            if (n == 3) check({tag, ":active_e3"}, 16'(active_signal), 16'h0001);
        end
        check({tag, ":latency"}, 16'(n), 16'd4);
        check({tag, ":active_done"}, 16'(active_signal), 16'h0000);
        check_outputs(tag);
        tick;
        check({tag, ":complete_1cyc"}, 16'(complete_signal), 16'h0000);
    endtask

    function automatic logic [15:0] rnd_rate();
        case ($urandom_range(0, 2))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(0, 1023) - 512);
            default: return 16'($urandom_range(0, 8191) - 4096);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int seen;
        logic [15:0] thr_r;

        resetn = 1'b0;
        start_signal = 1'b0;
        throttle_rate_target = '0;
        yaw_rate_target = '0; pitch_rate_target = '0; roll_rate_target = '0;
        yaw_rate_actual = '0; pitch_rate_actual = '0; roll_rate_actual = '0;
        for (int k = 0; k < 3; k++) begin
            m_integ[k] = 0;
            exp_rate[k] = 0;
        end
        exp_thr = 0;
        #23;
        check("reset:active", 16'(active_signal), 16'h0000);
        check("reset:complete", 16'(complete_signal), 16'h0000);
        check_outputs("reset");
        resetn = 1'b1;
        tick;

        run_update("pitch_p", 16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("pitch_p_const", pitch_rate_out, 16'h0200);

        for (int k = 0; k < 64; k++) begin
            run_update("roll_i", 16'h0320, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0000);
            if (k == 0) check("roll_first_const", roll_rate_out, 16'h0081);
        end
        check("roll_64th_const", roll_rate_out, 16'h00C0);
        run_update("roll_idle", 16'h0000, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 16'h0000, 16'h0000);
        check("roll_idle_const", roll_rate_out, 16'h0080);

        run_update("yaw_sat_pos", 16'h0320, 16'h7FF0, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000);
        check("yaw_pos_const", yaw_rate_out, 16'h0C80);
        run_update("yaw_sat_neg", 16'h0320, 16'h8000, 16'h0000, 16'h0000, 16'h7FF0, 16'h0000, 16'h0000);
        check("yaw_neg_const", yaw_rate_out, 16'hF380);

        for (int k = 0; k < 10; k++)
            run_update("windup", 16'h0320, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_update("windup_probe", 16'h0320, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("windup_i_const", pitch_rate_out, 16'h0100);

        // Abort an update in LIMITING with reset.
        throttle_rate_target = 16'h0320;
        yaw_rate_target = 16'h0100; pitch_rate_target = 16'h0200; roll_rate_target = 16'h0300;
        yaw_rate_actual = 16'h0000; pitch_rate_actual = 16'h0000; roll_rate_actual = 16'h0000;
        start_signal = 1'b1;
        tick;
        start_signal = 1'b0;
        tick; tick; tick;
        resetn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            m_integ[k] = 0;
            exp_rate[k] = 0;
        end
        exp_thr = 0;
        check("midrst:active", 16'(active_signal), 16'h0000);
        check("midrst:complete", 16'(complete_signal), 16'h0000);
        check_outputs("midrst");
        tick; tick;
        resetn = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (complete_signal !== 1'b0) seen++;
        end
        check("midrst:no_pulse", 16'(seen), 16'h0000);
        run_update("post_reset", 16'h0320, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("post_reset_i0", pitch_rate_out, 16'h0000);

        // Start held high: one update every 6 cycles, busy-time start ignored.
        throttle_rate_target = 16'hF000;
        yaw_rate_target = 16'h0100; pitch_rate_target = 16'hFFB0; roll_rate_target = 16'h0055;
        yaw_rate_actual = 16'h0010; pitch_rate_actual = 16'h0020; roll_rate_actual = 16'hFF00;
        start_signal = 1'b1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            tick;
            if (complete_signal === 1'b1) begin
                check("held:pulse_cycle", 16'(k), 16'(4 + 6 * pulses));
                model_step(16'hF000, 16'h0100, 16'hFFB0, 16'h0055, 16'h0010, 16'h0020, 16'hFF00);
                check_outputs("held");
                pulses++;
            end
        end
        start_signal = 1'b0;
        check("held:pulse_count", 16'(pulses), 16'd5);
        check("held:thr_neg_const", throttle_out, 16'h0000);

        run_update("thr_max", 16'h1200, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        check("thr_max_const", throttle_out, 16'h0FA0);
        repeat (5) tick;
        check_outputs("hold");

        for (int k = 0; k < 40; k++) begin
            thr_r = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 79)) : 16'($urandom);
            run_update("random", thr_r, rnd_rate(), rnd_rate(), rnd_rate(),
                       rnd_rate(), rnd_rate(), rnd_rate());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
